cr_iu_hs_uop_buf: RTL
=====================

// Module: cr_iu_hs_uop_buf
// PURPOSE
//  Micro-op buffer directly downstream of the hardware-stacking split unit.
//  Captures split push/pop micro-ops (inst op, retire mask, unstack chgflw
//  tag) and issues them in order to the IU execute stage.
//  Owns the back-pressure path: drives the split unit's ex-stall input from
//  its fill level, decoupling split generation from EX stalls.
// PARAMETERS
//  DEPTH  4  entries; power of 2, >=2; PTR_W=log2(DEPTH) is a localparam
// PORTS
//  forever_cpuclk                in   1   core clock
//  cpurst                        in   1   async reset, active-high
//  hs_split_iu_ctrl_inst_vld     in   1   split micro-op valid (push request)
//  hs_split_iu_dp_inst_op        in   32  split micro-op encoding
//  hs_split_iu_hs_retire_mask    in   1   suppress retire for this uop
//  hs_split_iu_unstack_chgflw    in   1   uop ends the unstack sequence (chgflw)
//  iu_yy_xx_flush                in   1   pipeline flush
//  ex_uop_buf_stall              in   1   EX cannot accept head uop this cycle
//  iu_hs_split_ex_stall          out  1   back-pressure to split unit (buffer full)
//  uop_buf_ex_inst_vld           out  1   head uop valid to EX
//  uop_buf_ex_inst_op            out  32  head uop encoding
//  uop_buf_ex_retire_mask        out  1   head uop retire mask
//  uop_buf_ex_unstack_chgflw     out  1   head uop chgflw tag
//  uop_buf_cnt                   out  PTR_W+1  occupancy, 0..DEPTH
//  uop_buf_ovf                   out  1   sticky: push attempted while full
// BEHAVIOUR
//  - Storage: DEPTH x 34b entries {chgflw, retire_mask, op}; wr_ptr, rd_ptr are
//    PTR_W bits and wrap modulo DEPTH; cnt is PTR_W+1 bits.
//  - Reset (async, cpurst=1): ptrs=0, cnt=0, ovf=0; all outputs 0; stall=0.
//    Entry storage is not reset. Reset mid-sequence discards all entries.
//  - full=(cnt==DEPTH), empty=(cnt==0). iu_hs_split_ex_stall=full (comb from
//    reg). No full-pass-through: stall stays high in a cycle that also pops.
//  - push=vld & ~full & ~flush: write entry at wr_ptr, wr_ptr++.
//  - pop=uop_buf_ex_inst_vld & ~ex_uop_buf_stall: rd_ptr++.
//  - cnt next: +1 on push only, -1 on pop only, unchanged on both/neither.
//  - Head outputs: vld=~empty & ~flush; op/mask/chgflw read combinationally
//    from entry[rd_ptr]; 0 when vld=0. No bypass: push in cycle N visible at
//    head no earlier than N+1.
//  - Head held stable while ex_uop_buf_stall=1.
//  - Flush: same cycle vld forced 0, push and pop suppressed; next edge
//    ptrs=0, cnt=0. ovf not cleared by flush (reset only).
//  - vld & full & ~flush: uop dropped, ovf<=1 (protocol violation).
//  - Order strictly FIFO across pointer wrap.
// TESTING
//  1. Push 0x11,0x22,0x33,0x44 back-to-back, ex stall=1 -> cnt=4 after 4th
//     edge, iu_hs_split_ex_stall=1, head op=0x11 held.
//  2. From (1) drop ex stall -> ops 0x11..0x44 popped one per cycle, stall
//     falls the cycle cnt=3, vld=0 after 4th pop.
//  3. cnt=2, push+pop same cycle -> cnt stays 2, head advances one entry.
//  4. cnt=3 with push asserted, flush=1 -> vld=0 that cycle, next cycle
//     cnt=0, ptrs=0, pushed uop absent.
//  5. 10 push/pop pairs 0xA0..0xA9 (wrap twice) -> popped in same order;
//     then push while full -> ovf=1, entry dropped, contents unchanged.
//  6. cnt=2, assert cpurst asynchronously mid-cycle -> all outputs 0
//     immediately; after release first push appears at head next cycle.

Source files
------------

// File: rtl/cr_iu_hs_uop_buf_if.sv
// Handshake bundle between the hardware-stacking split unit, the uop buffer and the IU EX stage.
// Valid/ready: a uop moves on any edge where its valid is high and the receiver's stall is low.
interface cr_iu_hs_uop_buf_if #(parameter int DEPTH = 4);
  localparam int PTR_W = $clog2(DEPTH);

  logic              hs_split_iu_ctrl_inst_vld;
  logic [31:0]       hs_split_iu_dp_inst_op;
  logic              hs_split_iu_hs_retire_mask;
  logic              hs_split_iu_unstack_chgflw;
  logic              iu_yy_xx_flush;
  logic              ex_uop_buf_stall;
  logic              iu_hs_split_ex_stall;
  logic              uop_buf_ex_inst_vld;
  logic [31:0]       uop_buf_ex_inst_op;
  logic              uop_buf_ex_retire_mask;
  logic              uop_buf_ex_unstack_chgflw;
  logic [PTR_W:0]    uop_buf_cnt;
  logic              uop_buf_ovf;

  modport master (
    output hs_split_iu_ctrl_inst_vld, hs_split_iu_dp_inst_op, hs_split_iu_hs_retire_mask,
           hs_split_iu_unstack_chgflw, iu_yy_xx_flush, ex_uop_buf_stall,
    input  iu_hs_split_ex_stall, uop_buf_ex_inst_vld, uop_buf_ex_inst_op, uop_buf_ex_retire_mask,
           uop_buf_ex_unstack_chgflw, uop_buf_cnt, uop_buf_ovf
  );

  modport slave (
    input  hs_split_iu_ctrl_inst_vld, hs_split_iu_dp_inst_op, hs_split_iu_hs_retire_mask,
           hs_split_iu_unstack_chgflw, iu_yy_xx_flush, ex_uop_buf_stall,
    output iu_hs_split_ex_stall, uop_buf_ex_inst_vld, uop_buf_ex_inst_op, uop_buf_ex_retire_mask,
           uop_buf_ex_unstack_chgflw, uop_buf_cnt, uop_buf_ovf
  );
endinterface

// File: rtl/cr_iu_hs_uop_buf.sv
// In-order micro-op FIFO between the HS split unit and IU EX; back-pressures the
// split unit from its own fill level so split generation is decoupled from EX stalls.
module cr_iu_hs_uop_buf #(
  parameter int DEPTH = 4
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  cr_iu_hs_uop_buf_if.slave     bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [33:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic        full, empty, push, pop, head_vld;
  logic [33:0] head_entry;

  assign full       = (cnt_q == FULL_CNT);
  assign empty      = (cnt_q == '0);
  assign head_vld   = ~empty & ~bus.iu_yy_xx_flush;
  assign head_entry = mem_q[rd_ptr_q];
  assign push       = bus.hs_split_iu_ctrl_inst_vld & ~full & ~bus.iu_yy_xx_flush;
  assign pop        = head_vld & ~bus.ex_uop_buf_stall;

  // Stall comes straight from the registered count: a pop in the same cycle
  // does not open a slot for the split unit until the next cycle.
  assign bus.iu_hs_split_ex_stall      = full;
  assign bus.uop_buf_ex_inst_vld       = head_vld;
  assign bus.uop_buf_ex_inst_op        = head_vld ? head_entry[31:0] : 32'h0;
  assign bus.uop_buf_ex_retire_mask    = head_vld & head_entry[32];
  assign bus.uop_buf_ex_unstack_chgflw = head_vld & head_entry[33];
  assign bus.uop_buf_cnt               = cnt_q;
  assign bus.uop_buf_ovf               = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | (bus.hs_split_iu_ctrl_inst_vld & full & ~bus.iu_yy_xx_flush);
    if (bus.iu_yy_xx_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
      else if (pop && !push) cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage is intentionally not reset; validity is tracked by cnt_q alone.
  always_ff @(posedge forever_cpuclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.hs_split_iu_unstack_chgflw,
                          bus.hs_split_iu_hs_retire_mask,
                          bus.hs_split_iu_dp_inst_op};
    end
  end
endmodule
